muldiv_sequencer: RTL

Sequencer for the shared multiply/divide resource of the multicycle CPU. It accepts a mult/div request from the main control FSM and launches the Mult or Div unit with a one-cycle start pulse. It then waits for that unit's done flag, steers and strobes the HI/LO registers, and reports completion, divide-by-zero or timeout back to the control FSM. It owns HICtrl/LOCtrl/WriteHI/WriteLO, so the control FSM only issues `start` and waits on `busy`.

---
 rtl/muldiv_sequencer_if.sv | 32 +++
 rtl/muldiv_sequencer.sv | 118 +++++++++++
 2 files changed

// File: rtl/muldiv_sequencer_if.sv
// Handshake between the CPU control FSM / Mult / Div units and the mult/div sequencer.
// The master drives requests and unit status; the slave (sequencer) drives launch, HI/LO control and status.
interface muldiv_sequencer_if;
    logic start;
    logic op;
    logic flush;
    logic mult_done;
    logic div_done;
    logic div0;
    logic mult_start;
    logic div_start;
    logic hi_sel;
    logic lo_sel;
    logic write_hi;
    logic write_lo;
    logic busy;
    logic done;
    logic exc_div0;
    logic exc_timeout;

    modport master (
        output start, op, flush, mult_done, div_done, div0,
        input  mult_start, div_start, hi_sel, lo_sel, write_hi, write_lo,
               busy, done, exc_div0, exc_timeout
    );

    modport slave (
        input  start, op, flush, mult_done, div_done, div0,
        output mult_start, div_start, hi_sel, lo_sel, write_hi, write_lo,
               busy, done, exc_div0, exc_timeout
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Launches the shared Mult or Div unit, waits for its completion and strobes HI/LO,
// reporting divide-by-zero or timeout back to the control FSM.
//
// state  | meaning
// IDLE   | waiting for start; hi_sel/lo_sel hold last value
// LAUNCH | one-cycle start pulse to the selected unit
// WAIT   | waiting for selected unit done / div0 / timeout
// WRITE  | HI/LO write strobe and done pulse
// FAULT  | exc_div0 or exc_timeout pulse, no HI/LO write
module muldiv_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 40
) (
    input  logic           clock,
    input  logic           reset,
    muldiv_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_WRITE,
        S_FAULT
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state, state_n;
    logic       op_q, op_n;
    logic       cause_q, cause_n;
    logic       sel_n;
    logic [7:0] cnt, cnt_n;
    logic       unit_done;

    assign unit_done = op_q ? bus.div_done : bus.mult_done;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            op_q    <= 1'b0;
            cause_q <= 1'b0;
            cnt     <= 8'd0;
        end else begin
            state   <= state_n;
            op_q    <= op_n;
            cause_q <= cause_n;
            cnt     <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        op_n    = op_q;
        cause_n = cause_q;
        cnt_n   = cnt;
        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
                    op_n    = bus.op;
                    state_n = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cnt_n   = 8'd0;
                state_n = bus.flush ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (bus.flush) begin
                    state_n = S_IDLE;
                end else if (op_q && bus.div0) begin
                    cause_n = 1'b0;
                    state_n = S_FAULT;
                end else if (unit_done) begin
                    state_n = S_WRITE;
                end else if (cnt == CNT_LAST) begin
                    cause_n = 1'b1;
                    state_n = S_FAULT;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            S_WRITE: state_n = S_IDLE;
            S_FAULT: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Mux selects are captured on entry to LAUNCH and held afterwards so mfhi/mflo see stable paths.
    assign sel_n = (state_n == S_LAUNCH) ? ~op_n : bus.hi_sel;

    // Moore outputs registered from the next state so each is a clean flop output.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.mult_start  <= 1'b0;
            bus.div_start   <= 1'b0;
            bus.hi_sel      <= 1'b0;
            bus.lo_sel      <= 1'b0;
            bus.write_hi    <= 1'b0;
            bus.write_lo    <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.exc_div0    <= 1'b0;
            bus.exc_timeout <= 1'b0;
        end else begin
            bus.mult_start  <= (state_n == S_LAUNCH) && !op_n;
            bus.div_start   <= (state_n == S_LAUNCH) && op_n;
            bus.hi_sel      <= sel_n;
            bus.lo_sel      <= sel_n;
            bus.write_hi    <= (state_n == S_WRITE);
            bus.write_lo    <= (state_n == S_WRITE);
            bus.busy        <= (state_n != S_IDLE);
            bus.done        <= (state_n == S_WRITE);
            bus.exc_div0    <= (state_n == S_FAULT) && !cause_n;
            bus.exc_timeout <= (state_n == S_FAULT) && cause_n;
        end
    end

endmodule
